// File: rtl/pwm_timer_if.sv
// PWM timer control/status bundle: staged period/compare, tick, enable and outputs.
// No latency of its own; pure wiring between the timer and its controller.
// No backpressure: load_i is a single-cycle strobe, outputs are level/pulse.
interface pwm_timer_if #(
    parameter int WIDTH = 16
);
    logic             tick_i;
    logic             en_i;
    logic [WIDTH-1:0] arr_i;
    logic [WIDTH-1:0] ccr_i;
    logic             load_i;
    logic             pending_o;
    logic [WIDTH-1:0] cnt_o;
    logic             pwm_o;
    logic             upd_o;
`ifdef PWM_TIMER_DEADTIME_EN
    logic [7:0]       dt_i;
    logic             pwm_n_o;

    modport master (
        output tick_i, en_i, arr_i, ccr_i, load_i, dt_i,
        input  pending_o, cnt_o, pwm_o, upd_o, pwm_n_o
    );
    modport slave (
        input  tick_i, en_i, arr_i, ccr_i, load_i, dt_i,
        output pending_o, cnt_o, pwm_o, upd_o, pwm_n_o
    );
`else
    modport master (
        output tick_i, en_i, arr_i, ccr_i, load_i,
        input  pending_o, cnt_o, pwm_o, upd_o
    );
    modport slave (
        input  tick_i, en_i, arr_i, ccr_i, load_i,
        output pending_o, cnt_o, pwm_o, upd_o
    );
`endif
endinterface

// File: rtl/pwm_timer.sv
// PWM timer with shadowed period/compare; optional dead time via PWM_TIMER_DEADTIME_EN.
// Latency: cnt_o/pwm_o/upd_o update one clk_i after the tick_i rising edge is seen.
// No backpressure: loads are always accepted, last load before the wrap wins.
module pwm_timer #(
    parameter int WIDTH   = 16,
    parameter int ARR_RST = 99,
    parameter int CCR_RST = 50
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    pwm_timer_if.slave   bus
);
    localparam logic [WIDTH-1:0] ARR_INIT = WIDTH'(ARR_RST);
    localparam logic [WIDTH-1:0] CCR_INIT = WIDTH'(CCR_RST);

    logic             tick_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] arr_sh_q, arr_sh_d, ccr_sh_q, ccr_sh_d;
    logic [WIDTH-1:0] arr_stg_q, arr_stg_d, ccr_stg_q, ccr_stg_d;
    logic             pend_q, pend_d;
    logic             pwm_q, pwm_d;
    logic             upd_q, upd_d;
    logic             adv, wrap;

    always_comb begin
        adv       = bus.tick_i & ~tick_q & bus.en_i;
        wrap      = adv && (cnt_q >= arr_sh_q);
        cnt_d     = cnt_q;
        arr_sh_d  = arr_sh_q;
        ccr_sh_d  = ccr_sh_q;
        arr_stg_d = arr_stg_q;
        ccr_stg_d = ccr_stg_q;
        pend_d    = pend_q;
        pwm_d     = pwm_q;
        upd_d     = wrap;

        // A load landing on the wrap edge bypasses staging and takes effect now.
        if (bus.load_i) begin
            arr_stg_d = bus.arr_i;
            ccr_stg_d = bus.ccr_i;
            pend_d    = ~wrap;
        end
        if (wrap) begin
            if (bus.load_i) begin
                arr_sh_d = bus.arr_i;
                ccr_sh_d = bus.ccr_i;
            end else if (pend_q) begin
                arr_sh_d = arr_stg_q;
                ccr_sh_d = ccr_stg_q;
                pend_d   = 1'b0;
            end
        end
        if (adv) begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
            pwm_d = (cnt_d < ccr_sh_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            arr_sh_q  <= ARR_INIT;
            ccr_sh_q  <= CCR_INIT;
            arr_stg_q <= ARR_INIT;
            ccr_stg_q <= CCR_INIT;
            pend_q    <= 1'b0;
            pwm_q     <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            tick_q    <= bus.tick_i;
            cnt_q     <= cnt_d;
            arr_sh_q  <= arr_sh_d;
            ccr_sh_q  <= ccr_sh_d;
            arr_stg_q <= arr_stg_d;
            ccr_stg_q <= ccr_stg_d;
            pend_q    <= pend_d;
            pwm_q     <= pwm_d;
            upd_q     <= upd_d;
        end
    end

    assign bus.cnt_o     = cnt_q;
    assign bus.pending_o = pend_q;
    assign bus.upd_o     = upd_q;

`ifdef PWM_TIMER_DEADTIME_EN
    // Cycles since the raw PWM last changed level; saturates so long phases stay open.
    logic [7:0] dt_cnt_q, dt_cnt_d;

    always_comb begin
        if (pwm_d != pwm_q) begin
            dt_cnt_d = 8'd0;
        end else if (dt_cnt_q == 8'hFF) begin
            dt_cnt_d = dt_cnt_q;
        end else begin
            dt_cnt_d = dt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dt_cnt_q <= 8'd0;
        end else begin
            dt_cnt_q <= dt_cnt_d;
        end
    end

    assign bus.pwm_o   =  pwm_q && (dt_cnt_q >= bus.dt_i);
    assign bus.pwm_n_o = ~pwm_q && (dt_cnt_q >= bus.dt_i);
`else
    assign bus.pwm_o = pwm_q;
`endif
endmodule
